// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one operation at a time behind a busy/done handshake.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  logic [4:0]            rd_in,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [4:0]            rd_out,
    output logic                  wr_en
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] LAST    = CW'(DATA_WIDTH);
    localparam logic [W-1:0]  MIN_INT = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_nxt;
    logic [2:0]      op;
    logic            neg;
    logic [W-1:0]    b_mag;
    logic [2*W-1:0]  acc;
    logic [CW-1:0]   counter;

    logic            busy_nxt, done_nxt, wr_nxt;
    logic            load, step, finish;

    logic            sgn_a_in, sgn_b_in, neg_in;
    logic            div_zero_in, ovf_in, special_in;
    logic [W-1:0]    a_mag_in, b_mag_in, special_val;

    logic [W:0]      mul_sum, div_tmp, div_diff;
    logic            div_q;
    logic [2*W-1:0]  mul_step, div_step, prod;
    logic [W-1:0]    mul_out, div_sel, div_out, calc_out;

    // Operand decode at acceptance: signedness, magnitudes, result sign, special cases
    always_comb begin
        sgn_a_in = 1'b0;
        sgn_b_in = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                sgn_a_in = op_a[W-1];
                sgn_b_in = op_b[W-1];
            end
            3'b010: sgn_a_in = op_a[W-1];
            default: begin
                sgn_a_in = 1'b0;
                sgn_b_in = 1'b0;
            end
        endcase
        a_mag_in    = sgn_a_in ? -op_a : op_a;
        b_mag_in    = sgn_b_in ? -op_b : op_b;
        neg_in      = (funct3 == 3'b110) ? sgn_a_in : (sgn_a_in ^ sgn_b_in);
        div_zero_in = funct3[2] && (op_b == '0);
        ovf_in      = funct3[2] && !funct3[0] && (op_a == MIN_INT) && (op_b == '1);
        special_in  = div_zero_in || ovf_in;
        if (div_zero_in)
            special_val = funct3[1] ? op_a : '1;
        else
            special_val = funct3[1] ? '0 : MIN_INT;
    end

    // One multiply or divide iteration, plus the final sign fix / half select
    always_comb begin
        mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, b_mag} : '0);
        mul_step = {mul_sum, acc[W-1:1]};
        div_tmp  = {acc[2*W-1:W], acc[W-1]};
        div_diff = div_tmp - {1'b0, b_mag};
        div_q    = ~div_diff[W];
        div_step = {(div_q ? div_diff[W-1:0] : div_tmp[W-1:0]), acc[W-2:0], div_q};
        prod     = neg ? -acc : acc;
        mul_out  = (op[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
        div_sel  = op[1] ? acc[2*W-1:W] : acc[W-1:0];
        div_out  = neg ? -div_sel : div_sel;
        calc_out = op[2] ? div_out : mul_out;
    end

    always_comb begin
        state_nxt = state;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    busy_nxt = 1'b1;
                    if (special_in) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                busy_nxt = 1'b1;
                // counter == LAST means all iterations are in acc; this edge only writes result
                if (counter == LAST) begin
                    finish    = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        wr_nxt = done_nxt && ((load ? rd_in : rd_out) != 5'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            wr_en <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            wr_en <= wr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op      <= '0;
            neg     <= 1'b0;
            b_mag   <= '0;
            acc     <= '0;
            counter <= '0;
            result  <= '0;
            rd_out  <= '0;
        end else if (load) begin
            op      <= funct3;
            neg     <= neg_in;
            b_mag   <= b_mag_in;
            acc     <= {{W{1'b0}}, a_mag_in};
            counter <= '0;
            rd_out  <= rd_in;
            if (special_in)
                result <= special_val;
        end else if (step) begin
            acc     <= op[2] ? div_step : mul_step;
            counter <= counter + CW'(1);
        end else if (finish) begin
            result  <= calc_out;
            counter <= '0;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model with a per-cycle output checker,
// driven by directed RV32M vectors carrying hand-computed results and latencies.
module tb_muldiv_unit;
    localparam int W = 32;
    localparam logic [31:0] MIN_INT = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done, wr_en;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int vectors = 0;
    int errors  = 0;

    muldiv_unit #(.DATA_WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out),
        .wr_en  (wr_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // RV32M semantics straight from 64-bit integer arithmetic
    function automatic logic [31:0] model_res(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = '0;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == MIN_INT && b == 32'hFFFF_FFFF) return MIN_INT;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
        return f[2] && ((b == 32'd0) || (!f[0] && a == MIN_INT && b == 32'hFFFF_FFFF));
    endfunction

    // Model state: age counts cycles since the accepting edge; done shows at done_age
    bit          m_active = 1'b0;
    int          m_age = 0;
    int          m_done_age = 0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_result = '0;
    logic [4:0]  m_rd = '0;
    logic        exp_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_age    <= 0;
            m_result <= '0;
            m_rd     <= '0;
        end else if (m_active) begin
            if (m_age == m_done_age) begin
                m_active <= 1'b0;
            end else begin
                m_age <= m_age + 1;
                if (m_age + 1 == m_done_age) m_result <= m_pend;
            end
        end else if (start) begin
            m_active   <= 1'b1;
            m_age      <= 0;
            m_pend     <= model_res(funct3, op_a, op_b);
            m_rd       <= rd_in;
            m_done_age <= is_special(funct3, op_a, op_b) ? 0 : W + 1;
            if (is_special(funct3, op_a, op_b)) m_result <= model_res(funct3, op_a, op_b);
        end
    end

    always @(negedge clk) begin
        exp_done = m_active && (m_age == m_done_age);
        chk("busy",   {31'd0, busy},  {31'd0, m_active});
        chk("done",   {31'd0, done},  {31'd0, exp_done});
        chk("wr_en",  {31'd0, wr_en}, {31'd0, exp_done && (m_rd != 5'd0)});
        chk("result", result, m_result);
        chk("rd_out", {27'd0, rd_out}, {27'd0, m_rd});
    end

    // lit_edges: clock edges from the accepting edge to the edge that raises done
    task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit use_lit, input logic [31:0] lit,
                       input int lit_edges, input bit reprobe);
        int n;
        @(negedge clk);
        funct3 = f;
        op_a   = a;
        op_b   = b;
        rd_in  = rd;
        start  = 1'b1;
        if (use_lit) chk("model_pin", model_res(f, a, b), lit);
        @(posedge clk);
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            start = reprobe && ((n % 8 == 3) || done);
            if (done) break;
        end
        if (n == 50) begin
            vectors++;
            errors++;
            $display("FAIL done_timeout: got no done within 50 cycles, expected done");
        end else begin
            if (use_lit) begin
                chk("op_result", result, lit);
                chk("op_edges", 32'(n), 32'(lit_edges));
            end
            chk("op_wr_en", {31'd0, wr_en}, {31'd0, rd != 5'd0});
            chk("op_rd_out", {27'd0, rd_out}, {27'd0, rd});
        end
        @(negedge clk);
        start = 1'b0;
        if (reprobe) chk("single_done", {31'd0, done}, 32'd0);
    endtask

    initial begin
        #22 rst_n = 1'b1;
        // multiply
        run(3'd0, 32'd7,        32'hFFFF_FFFD, 5'd5,  1, 32'hFFFF_FFEB, 33, 0);
        run(3'd1, MIN_INT,      MIN_INT,       5'd6,  1, 32'h4000_0000, 33, 0);
        run(3'd3, MIN_INT,      MIN_INT,       5'd7,  1, 32'h4000_0000, 33, 0);
        run(3'd2, 32'hFFFF_FFFF, 32'd2,        5'd8,  1, 32'hFFFF_FFFF, 33, 0);
        run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1, 32'hFFFF_FFFE, 33, 0);
        run(3'd1, 32'hFFFF_FFF9, 32'd3,        5'd10, 1, 32'hFFFF_FFFF, 33, 0);
        run(3'd0, 32'h0000_1234, 32'd0,        5'd11, 1, 32'd0,         33, 0);
        // divide
        run(3'd4, 32'd20,       32'hFFFF_FFFA, 5'd12, 1, 32'hFFFF_FFFD, 33, 0);
        run(3'd6, 32'd20,       32'hFFFF_FFFA, 5'd13, 1, 32'd2,         33, 0);
        run(3'd7, 32'd20,       32'd6,         5'd14, 1, 32'd2,         33, 0);
        run(3'd5, 32'hFFFF_FFFF, 32'd2,        5'd15, 1, 32'h7FFF_FFFF, 33, 0);
        run(3'd4, 32'hFFFF_FFF9, 32'd2,        5'd16, 1, 32'hFFFF_FFFD, 33, 0);
        run(3'd6, 32'hFFFF_FFF9, 32'd2,        5'd17, 1, 32'hFFFF_FFFF, 33, 0);
        // special cases bypass the iteration
        run(3'd4, 32'd5,        32'd0,         5'd18, 1, 32'hFFFF_FFFF, 0, 0);
        run(3'd7, 32'd5,        32'd0,         5'd19, 1, 32'd5,         0, 0);
        run(3'd4, MIN_INT,      32'hFFFF_FFFF, 5'd20, 1, MIN_INT,       0, 0);
        run(3'd6, MIN_INT,      32'hFFFF_FFFF, 5'd21, 1, 32'd0,         0, 0);
        run(3'd5, 32'd9,        32'd0,         5'd22, 1, 32'hFFFF_FFFF, 0, 0);
        // x0 destination and start re-pulsed while busy
        run(3'd0, 32'd6,        32'd7,         5'd0,  1, 32'd42,        33, 1);
        run(3'd4, 32'd5,        32'd0,         5'd0,  1, 32'hFFFF_FFFF, 0, 1);
        run(3'd0, 32'd3,        32'd5,         5'd1,  1, 32'd15,        33, 0);

        // abort in the middle of CALC
        @(negedge clk);
        funct3 = 3'd0; op_a = 32'd100; op_b = 32'd100; rd_in = 5'd23; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy",   {31'd0, busy},  32'd0);
        chk("rst_done",   {31'd0, done},  32'd0);
        chk("rst_wr_en",  {31'd0, wr_en}, 32'd0);
        chk("rst_result", result,         32'd0);
        chk("rst_rd_out", {27'd0, rd_out}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        run(3'd5, 32'd100,      32'd7,         5'd24, 1, 32'd14,        33, 0);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i % 4 == 3) ? 32'd0 : $urandom;
            run(3'($urandom_range(0, 7)), ra, rb, 5'($urandom_range(0, 31)), 0, 32'd0, 0, 0);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
